// File: rtl/audio_samples.sv
// Shared sample table for the game controller and the audio sample player.
// Holds the sample index names, the start/length tables (length 0 marks an
// unused index), the idle PCM level and the player's state encoding.
package audio_samples;

  localparam int SAMPLE_BITS      = 4;
  localparam int SAMPLE_COUNT     = 2 ** SAMPLE_BITS;
  localparam int SAMPLE_ADDR_BITS = 14;

  typedef logic [SAMPLE_ADDR_BITS-1:0] sample_addr_t;
  typedef logic [SAMPLE_ADDR_BITS:0]   sample_len_t;

  typedef enum logic [SAMPLE_BITS-1:0] {
    Sample_walls      = 4'd0,
    Sample_paddle     = 4'd1,
    Sample_lostBall   = 4'd2,
    Sample_blockStart = 4'd3
  } sample_id_t;

  localparam logic [7:0] PCM_IDLE = 8'h80;

  localparam sample_addr_t SAMPLE_START [SAMPLE_COUNT] = '{
    14'h0000, 14'h0100, 14'h0200, 14'h3FFE,
    14'h0000, 14'h0000, 14'h0000, 14'h0000,
    14'h0000, 14'h0000, 14'h0000, 14'h0000,
    14'h0000, 14'h0000, 14'h0000, 14'h0000
  };

  localparam sample_len_t SAMPLE_LEN [SAMPLE_COUNT] = '{
    15'd512, 15'd3, 15'd4, 15'd3,
    15'd0,   15'd0, 15'd0, 15'd0,
    15'd0,   15'd0, 15'd0, 15'd0,
    15'd0,   15'd0, 15'd0, 15'd0
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } player_state_t;

endpackage

// File: rtl/pwm_modulator.sv
// Free-running PWM: output is high for DUTY out of every 2^PWM_BITS cycles.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   DUTY         : duty value (0 = always low)
//   PWM          : registered modulated output
module pwm_modulator #(
  parameter int PWM_BITS = 8
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [PWM_BITS-1:0] DUTY,
  output logic                PWM
);

  logic [PWM_BITS-1:0] cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
      PWM <= 1'b0;
    end else begin
      cnt <= cnt + PWM_BITS'(1);
      PWM <= (cnt < DUTY);
    end
  end

endmodule

// File: rtl/audio_sample_player.sv
// Plays 8-bit unsigned PCM samples from an external synchronous ROM at one
// byte per CLK_DIV cycles, started by a one-cycle trigger and looked up in
// the shared sample table.
//   CLK, RESET_N   : clock, asynchronous active-low reset
//   AUDIO_SELECT   : sample index, valid with AUDIO_TRIGGER
//   AUDIO_TRIGGER  : one-cycle start strobe (latest trigger preempts)
//   ROM_ADDR       : registered ROM address
//   ROM_DATA       : ROM read data, valid one cycle after ROM_ADDR
//   PCM_OUT        : current PCM byte, PCM_IDLE when idle
//   AUDIO_PWM      : PWM-modulated PCM_OUT
//   PLAYING        : high while a sample is in progress
module audio_sample_player
  import audio_samples::*;
#(
  parameter int SAMPLE_BITS   = 4,
  parameter int ROM_ADDR_BITS = 14,
  parameter int CLK_DIV       = 3125,
  parameter int PWM_BITS      = 8
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [SAMPLE_BITS-1:0]   AUDIO_SELECT,
  input  logic                     AUDIO_TRIGGER,
  output logic [ROM_ADDR_BITS-1:0] ROM_ADDR,
  input  logic [7:0]               ROM_DATA,
  output logic [PWM_BITS-1:0]      PCM_OUT,
  output logic                     AUDIO_PWM,
  output logic                     PLAYING
);

  localparam int TICK_W = $clog2(CLK_DIV);
  localparam int LEN_W  = ROM_ADDR_BITS + 1;

  player_state_t            state, state_n;
  logic [ROM_ADDR_BITS-1:0] addr, addr_n;
  logic [LEN_W-1:0]         remaining, remaining_n;
  logic [TICK_W-1:0]        tick, tick_n;
  logic [PWM_BITS-1:0]      pcm, pcm_n;
  logic                     playing, playing_n;
  logic                     tail, tail_n;

  logic [ROM_ADDR_BITS-1:0] trig_start;
  logic [LEN_W-1:0]         trig_len;
  logic                     tick_end;

  assign trig_start = ROM_ADDR_BITS'(SAMPLE_START[AUDIO_SELECT]);
  assign trig_len   = LEN_W'(SAMPLE_LEN[AUDIO_SELECT]);
  assign tick_end   = (tick == TICK_W'(CLK_DIV - 1));

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    tick_n      = tick;
    pcm_n       = pcm;
    playing_n   = playing;
    tail_n      = tail;

    unique case (state)
      IDLE: begin
        // tail: the last byte is held one full period before returning idle
        if (tail) begin
          if (tick_end) begin
            tick_n = '0;
            tail_n = 1'b0;
            pcm_n  = PWM_BITS'(PCM_IDLE);
          end else begin
            tick_n = tick + TICK_W'(1);
          end
        end
      end
      FETCH: begin
        tick_n  = tick + TICK_W'(1);
        state_n = LATCH;
      end
      LATCH: begin
        pcm_n       = PWM_BITS'(ROM_DATA);
        addr_n      = addr + ROM_ADDR_BITS'(1);
        remaining_n = remaining - LEN_W'(1);
        if (remaining == LEN_W'(1)) begin
          // Tail period restarts at the final latch so the hold is exactly
          // CLK_DIV cycles measured from the byte appearing on PCM_OUT.
          state_n   = IDLE;
          playing_n = 1'b0;
          tail_n    = 1'b1;
          tick_n    = '0;
        end else begin
          tick_n  = tick + TICK_W'(1);
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (tick_end) begin
          tick_n  = '0;
          state_n = FETCH;
        end else begin
          tick_n = tick + TICK_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // A valid trigger overrides everything, including a coincident latch.
    if (AUDIO_TRIGGER && (trig_len != '0)) begin
      state_n     = FETCH;
      addr_n      = trig_start;
      remaining_n = trig_len;
      tick_n      = '0;
      pcm_n       = pcm;
      playing_n   = 1'b1;
      tail_n      = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      tick      <= '0;
      pcm       <= PWM_BITS'(PCM_IDLE);
      playing   <= 1'b0;
      tail      <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= remaining_n;
      tick      <= tick_n;
      pcm       <= pcm_n;
      playing   <= playing_n;
      tail      <= tail_n;
    end
  end

  assign ROM_ADDR = addr;
  assign PCM_OUT  = pcm;
  assign PLAYING  = playing;

  pwm_modulator #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .DUTY   (pcm),
    .PWM    (AUDIO_PWM)
  );

endmodule

// File: tb/tb_audio_sample_player.sv
// Scoreboard bench for audio_sample_player with a fast sample rate.
module tb_audio_sample_player;
  import audio_samples::*;

  localparam int D        = 4;
  localparam int ADDR_MOD = 16384;
  localparam int K_PCM    = 0;
  localparam int K_ADDR   = 1;
  localparam int K_PLAY   = 2;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [3:0]  AUDIO_SELECT = '0;
  logic        AUDIO_TRIGGER = 1'b0;
  logic [13:0] ROM_ADDR;
  logic [7:0]  ROM_DATA = '0;
  logic [7:0]  PCM_OUT;
  logic        AUDIO_PWM;
  logic        PLAYING;

  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  ev_t  q[$];
  logic [7:0]  exp_pcm = 8'h80;
  logic [13:0] exp_addr = '0;
  logic        exp_play = 1'b0;
  logic [7:0]  last_pcm;
  logic [13:0] last_addr;
  logic        last_play;
  bit          rom_const_en = 1'b0;
  logic [7:0]  rom_const = '0;

  audio_sample_player #(
    .SAMPLE_BITS  (4),
    .ROM_ADDR_BITS(14),
    .CLK_DIV      (D),
    .PWM_BITS     (8)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .AUDIO_SELECT (AUDIO_SELECT),
    .AUDIO_TRIGGER(AUDIO_TRIGGER),
    .ROM_ADDR     (ROM_ADDR),
    .ROM_DATA     (ROM_DATA),
    .PCM_OUT      (PCM_OUT),
    .AUDIO_PWM    (AUDIO_PWM),
    .PLAYING      (PLAYING)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [7:0] rom_byte(input int a);
    logic [31:0] av;
    av = a;
    return rom_const_en ? rom_const : av[7:0];
  endfunction

  always @(posedge CLK) ROM_DATA <= rom_byte(int'(ROM_ADDR));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a trigger taking effect at edge e fully determines the output
  // timeline from e onward, so pending events at or after e are discarded.
  task automatic model_trigger(input int idx, input int e);
    int len;
    int start;
    len   = int'(SAMPLE_LEN[idx]);
    start = int'(SAMPLE_START[idx]);
    if (len == 0) return;
    while (q.size() > 0 && q[$].cyc >= e) void'(q.pop_back());
    q.push_back('{e, K_ADDR, start});
    q.push_back('{e, K_PLAY, 1});
    for (int n = 0; n < len; n++) begin
      int l;
      l = e + 2 + n * D;
      q.push_back('{l, K_PCM, int'(rom_byte((start + n) % ADDR_MOD))});
      q.push_back('{l, K_ADDR, (start + n + 1) % ADDR_MOD});
      if (n == len - 1) begin
        q.push_back('{l, K_PLAY, 0});
        q.push_back('{l + D, K_PCM, 128});
      end
    end
  endtask

  always @(negedge CLK) begin
    bit  popped;
    ev_t ev;
    popped = 1'b0;
    if (!RESET_N) begin
      q.delete();
      exp_pcm  = 8'h80;
      exp_addr = '0;
      exp_play = 1'b0;
    end else begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        ev = q.pop_front();
        popped = 1'b1;
        case (ev.kind)
          K_PCM:   exp_pcm  = ev.val[7:0];
          K_ADDR:  exp_addr = ev.val[13:0];
          default: exp_play = ev.val[0];
        endcase
      end
      if (popped || PCM_OUT !== last_pcm || ROM_ADDR !== last_addr || PLAYING !== last_play) begin
        check("pcm_out", 32'(PCM_OUT), 32'(exp_pcm));
        check("rom_addr", 32'(ROM_ADDR), 32'(exp_addr));
        check("playing", 32'(PLAYING), 32'(exp_play));
      end
    end
    last_pcm  = PCM_OUT;
    last_addr = ROM_ADDR;
    last_play = PLAYING;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Called just after an edge; the trigger is sampled at the following edge.
  task automatic issue(input int idx);
    logic [31:0] iv;
    iv = idx;
    AUDIO_SELECT  = iv[3:0];
    AUDIO_TRIGGER = 1'b1;
    model_trigger(idx, cyc + 1);
    @(posedge CLK);
    #1;
    AUDIO_TRIGGER = 1'b0;
    AUDIO_SELECT  = 4'($urandom);
  endtask

  task automatic pwm_window(input string name, input int exp_high);
    int hi;
    hi = 0;
    repeat (256) begin
      @(negedge CLK);
      if (AUDIO_PWM) hi++;
    end
    check(name, 32'(hi), 32'(exp_high));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] duties [3];
    duties = '{8'h40, 8'hFF, 8'h00};

    #12;
    check("rst_pcm", 32'(PCM_OUT), 32'h80);
    check("rst_addr", 32'(ROM_ADDR), 32'h0);
    check("rst_playing", 32'(PLAYING), 32'h0);
    check("rst_pwm", 32'(AUDIO_PWM), 32'h0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    wait_cycles(3);

    issue(Sample_paddle);
    wait_cycles(20);

    issue(Sample_paddle);
    wait_cycles(5);
    issue(5);
    wait_cycles(20);

    issue(Sample_paddle);
    wait_cycles(7);
    issue(Sample_lostBall);
    wait_cycles(25);

    // retrigger landing on the final-byte edge
    issue(Sample_paddle);
    wait_cycles(9);
    issue(Sample_paddle);
    wait_cycles(20);

    issue(Sample_blockStart);
    wait_cycles(20);

    // asynchronous reset in the middle of a hold period
    issue(Sample_walls);
    wait_cycles(2);
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_rst_playing", 32'(PLAYING), 32'h0);
    check("async_rst_pcm", 32'(PCM_OUT), 32'h80);
    check("async_rst_addr", 32'(ROM_ADDR), 32'h0);
    wait_cycles(3);
    RESET_N = 1'b1;
    wait_cycles(2);
    issue(Sample_paddle);
    wait_cycles(20);

    for (int i = 0; i < 60; i++) begin
      int idx;
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 15)) : int'($urandom_range(1, 3));
      wait_cycles(int'($urandom_range(0, 14)));
      issue(idx);
    end
    wait_cycles(40);
    check("queue_drained", 32'(q.size()), 32'h0);

    rom_const_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rom_const = duties[i];
      issue(Sample_walls);
      wait_cycles(8);
      pwm_window($sformatf("pwm_high_%02h", duties[i]), int'(duties[i]));
    end

    RESET_N = 1'b0;
    wait_cycles(2);
    RESET_N = 1'b1;
    wait_cycles(4);
    pwm_window("pwm_high_idle", int'(PCM_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/audio_sample_player.md
Name: audio_sample_player

Overview:
Consumer end of the game controller's audio interface. Takes the one-cycle AUDIO_SELECT/AUDIO_TRIGGER event, finds the sample's start address and length in the shared sample table, and streams 8-bit unsigned PCM bytes from an external synchronous sample ROM at a fixed sample rate. Its outputs are a registered PCM byte and a 1-bit PWM audio pin. It sits between the game controller and the board audio output.

Parameters:
SAMPLE_BITS, 4, width of AUDIO_SELECT; must match the width in the shared sample package
ROM_ADDR_BITS, 14, sample ROM address width
CLK_DIV, 3125, CLK cycles per PCM sample (50 MHz / 16 kHz); minimum legal value 4
PWM_BITS, 8, PWM counter and PCM width

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous reset, active-low
AUDIO_SELECT  in  SAMPLE_BITS  sample index; valid only while AUDIO_TRIGGER is high
AUDIO_TRIGGER  in  1  one-cycle start strobe
ROM_ADDR  out  ROM_ADDR_BITS  registered sample-ROM address
ROM_DATA  in  8  ROM read data; valid one cycle after ROM_ADDR changes
PCM_OUT  out  8  current unsigned PCM sample; idle value is 8'h80
AUDIO_PWM  out  1  PWM-modulated PCM_OUT
PLAYING  out  1  high while a sample is in progress

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - state=IDLE
  - ROM_ADDR=0, PCM_OUT=8'h80, PLAYING=0, AUDIO_PWM=0
  - tick and PWM counters = 0
  - Asserting reset mid-playback aborts the sample immediately. No resume after release.
- State machine: IDLE, FETCH, LATCH, HOLD.
- Trigger (any state):
  - Look up start=SAMPLE_START[AUDIO_SELECT] and len=SAMPLE_LEN[AUDIO_SELECT].
  - If len=0 (unused index), ignore the trigger; current playback continues untouched.
  - Otherwise, on the next edge: ROM_ADDR<=start, remaining<=len, tick<=0, PLAYING<=1, state<=FETCH.
  - The latest trigger always preempts. A trigger in the same cycle as the end of a sample wins (PLAYING stays 1).
- FETCH (1 cycle): ROM_DATA for ROM_ADDR becomes valid. Go to LATCH.
- LATCH (1 cycle):
  - PCM_OUT<=ROM_DATA, ROM_ADDR<=ROM_ADDR+1 (wraps modulo 2^ROM_ADDR_BITS), remaining<=remaining-1.
  - If remaining was 1: state<=IDLE, PLAYING<=0, and PCM_OUT keeps the last byte for one full sample period before returning to 8'h80.
  - Otherwise state<=HOLD.
- HOLD: tick counts CLK cycles from the trigger/previous FETCH. When tick==CLK_DIV-1: tick<=0, state<=FETCH. Sample period is exactly CLK_DIV cycles.
- Latency: trigger at edge t → ROM_ADDR=start after t+1 → PCM_OUT=first byte after t+3. Byte n is at t+3+n*CLK_DIV.
- Idle return:
  - After the final byte's period expires, PCM_OUT<=8'h80.
  - tick keeps counting in IDLE for this one period only, then stops at 0.
- PWM:
  - Free-running PWM_BITS counter, not affected by triggers.
  - AUDIO_PWM registered = (pwm_cnt < PCM_OUT), giving PCM/256 duty.
  - PCM_OUT=0 gives a constant 0; PCM_OUT=255 gives high 255 of every 256 cycles.
- Widths: remaining is ROM_ADDR_BITS+1 wide. Tick counter is clog2(CLK_DIV) wide. All counters are unsigned with no saturation except as stated.

Decomposition:
- Shared package audio_samples:
  - SAMPLE_BITS
  - named indices (Sample_walls, Sample_paddle, Sample_lostBall, Sample_blockStart)
  - SAMPLE_START[] and SAMPLE_LEN[] constant tables (len 0 for unused indices)
  - PCM_IDLE=8'h80
- The game controller and this block include the same package.
- One sub-module: pwm_modulator, parameterised by PWM_BITS, with inputs CLK, RESET_N, DUTY and output PWM.

Test Plan:
- Bench setup: CLK_DIV=4; table Sample_paddle start=0x0100 len=3; ROM returns the low address byte.
- Trigger Sample_paddle at t → ROM_ADDR=0x0100 at t+1; PCM_OUT=0x00 at t+3, 0x01 at t+7, 0x02 at t+11; PLAYING falls at t+11; PCM_OUT=0x80 at t+15.
- Trigger an index with len=0 while Sample_paddle is playing → playback unaffected, byte sequence identical to the previous scenario.
- Retrigger Sample_lostBall (start=0x0200) at t+8 during paddle playback → ROM_ADDR=0x0200 at t+9; PCM_OUT=0x00 at t+11; PLAYING stays 1 throughout.
- Sample at start=0x3FFE len=3 → ROM_ADDR sequence 0x3FFE, 0x3FFF, 0x0000 (wrap); PCM_OUT bytes 0xFE, 0xFF, 0x00.
- Drop RESET_N asynchronously mid-HOLD → PLAYING=0, PCM_OUT=0x80, ROM_ADDR=0 before the next CLK edge. After release, the next trigger plays normally.
- PWM: hold PCM_OUT at 0x40 (idle preset via table) over 256 cycles → AUDIO_PWM high exactly 64 cycles. At 0x00 → high 0 cycles. At 0x80 idle → high 128 cycles.
